// File: rtl/des_key_sched_iter.sv
// Iterative DES key schedule: streams the 16 round subkeys one per accepted beat,
// in reverse (K16..K1) or forward (K1..K16) order.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, decrypt, key load request, order select, 64-bit DES key (key[63] = DES bit 1)
//   start_ready         high while idle (load accepted)
//   sk_valid, sk_ready  subkey stream handshake
//   sk_data             48-bit PC-2 output (bit 47 = PC-2 bit 1)
//   sk_round            round number minus 1 of the current subkey
//   sk_last             marks the 16th subkey of the sequence
module des_key_sched_iter #(
    parameter bit ENC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        start_ready,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] sk_data,
    output logic [3:0]  sk_round,
    output logic        sk_last
);

    localparam int unsigned HALF_W = 28;
    localparam int unsigned CD_W   = 56;
    localparam int unsigned SK_W   = 48;

    localparam int unsigned PC1_TBL [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TBL [SK_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit r set when round r+1 rotates by two (shift table 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).
    localparam logic [15:0] SHIFT2 = 16'b0111_1110_1111_1100;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [HALF_W-1:0]   c_q, c_d;
    logic [HALF_W-1:0]   d_q, d_d;
    logic                rev_q, rev_d;
    logic [3:0]          round_q, round_d;
    logic                last_q, last_d;
    logic                start_ready_q, start_ready_d;
    logic                valid_q, valid_d;

    logic [CD_W-1:0]     pc1_c;
    logic                load_rev_c;
    logic                two_c;
    logic                unused_parity;

    // Parity bits (DES bits 8,16,...,64) are not part of PC-1.
    assign unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

    function automatic logic [CD_W-1:0] pc1(input logic [63:0] k);
        logic [CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1_TBL[6'(i)])];
        end
        return r;
    endfunction

    function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2_TBL[6'(i)])];
        end
        return r;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    assign pc1_c      = pc1(key);
    assign load_rev_c = ENC_EN ? decrypt : 1'b1;
    // Forward uses the shift of the next round; reverse undoes the shift of the round just emitted.
    assign two_c      = rev_q ? SHIFT2[round_q] : SHIFT2[4'(round_q + 4'd1)];

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        rev_d   = rev_q;
        round_d = round_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rev_d   = load_rev_c;
                    // C16/D16 equal C0/D0, so reverse order starts unrotated.
                    if (load_rev_c) begin
                        c_d = pc1_c[55:28];
                        d_d = pc1_c[27:0];
                    end else begin
                        c_d = rotl(pc1_c[55:28], 1'b0);
                        d_d = rotl(pc1_c[27:0], 1'b0);
                    end
                    round_d = load_rev_c ? 4'd15 : 4'd0;
                    last_d  = 1'b0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (sk_ready) begin
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else if (rev_q) begin
                        c_d     = rotr(c_q, two_c);
                        d_d     = rotr(d_q, two_c);
                        round_d = round_q - 4'd1;
                        last_d  = (round_q == 4'd1);
                    end else begin
                        c_d     = rotl(c_q, two_c);
                        d_d     = rotl(d_q, two_c);
                        round_d = round_q + 4'd1;
                        last_d  = (round_q == 4'd14);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        start_ready_d = (state_d == IDLE);
        valid_d       = (state_d == EMIT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            c_q           <= '0;
            d_q           <= '0;
            rev_q         <= 1'b0;
            round_q       <= 4'd0;
            last_q        <= 1'b0;
            start_ready_q <= 1'b1;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            c_q           <= c_d;
            d_q           <= d_d;
            rev_q         <= rev_d;
            round_q       <= round_d;
            last_q        <= last_d;
            start_ready_q <= start_ready_d;
            valid_q       <= valid_d;
        end
    end

    assign start_ready = start_ready_q;
    assign sk_valid    = valid_q;
    assign sk_round    = round_q;
    assign sk_last     = last_q;
    // Subkey is decoded straight from the C/D registers, so it cannot depend on sk_ready.
    assign sk_data     = pc2({c_q, d_q});

endmodule

// File: doc/des_key_sched_iter.md
Name: des_key_sched_iter

Overview:
- Iterative DES round-key generator that streams the 16 48-bit subkeys one per handshake.
- Its main use is decryption order (K16 down to K1), using right rotations of C/D. It also supports encryption order (K1 up to K16), selected per key load.
- It sits between the key register and an iterative DES round core. It replaces the 16-wide combinational schedule where area matters.

Parameters:
- ENC_EN, 1: when 1, the `decrypt` input selects the order. When 0, `decrypt` is ignored and the order is always reverse.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start  in  1  load request; sampled only when `start_ready` = 1.
- decrypt  in  1  1 = reverse order (K16..K1), 0 = forward order (K1..K16). Sampled with `start`.
- key  in  64  DES key. key[63] = DES bit 1; parity bits are ignored.
- start_ready  out  1  1 while in IDLE.
- sk_valid  out  1  `sk_data` is valid.
- sk_ready  in  1  consumer accepts `sk_data`.
- sk_data  out  48  PC-2 output. Bit 47 = PC-2 bit 1.
- sk_round  out  4  DES round number minus 1 for the current subkey (K1 = 0, K16 = 15).
- sk_last  out  1  high with the 16th subkey of the sequence.

Behaviour:
- Reset values: start_ready = 1, sk_valid = 0, sk_last = 0, sk_round = 0, sk_data = 0. The internal C/D/count registers are also cleared.
- Shift table S[r] for rounds 1..16 is 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- FSM states:
  - IDLE: start_ready = 1, sk_valid = 0.
  - EMIT: start_ready = 0, sk_valid = 1.
- Load (IDLE, start = 1):
  - C/D are loaded with PC-1(key).
  - Forward order: C/D = rotl(PC-1, 1), so the first subkey is K1.
  - Reverse order: C/D = PC-1 unrotated, since C16 = C0; the first subkey is K16.
  - The mode bit is latched and the FSM moves to EMIT.
  - sk_valid rises on the cycle after start (latency 1).
- `sk_data` is combinational PC-2 of the C/D registers. It is held stable while sk_valid = 1 and sk_ready = 0.
- `sk_round`:
  - Forward: 0 for the first subkey, incrementing per accepted beat.
  - Reverse: 15 for the first subkey, decrementing per accepted beat.
- Advance on each accepted beat (sk_valid & sk_ready) that is not the last:
  - Forward: C/D rotate left by S[r+1], where r is the round just emitted.
  - Reverse: C/D rotate right by S[r], where r is the round just emitted (1-based), giving C_{r-1}.
  - Reverse rotate sequence (after K16, K15, ..., K2) is 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- sk_last = 1 exactly when:
  - sk_round = 15 in forward mode, or
  - sk_round = 0 in reverse mode.
- An accepted last beat returns the FSM to IDLE. On the next cycle sk_valid = 0 and start_ready = 1.
- A new start is not accepted in the same cycle as the last beat.
- start while in EMIT is ignored; it has no effect on the sequence.
- Back-pressure: with sk_ready held low indefinitely, all outputs are frozen.
- Asserting rst_n low mid-sequence clears everything immediately (asynchronous). After release the FSM is in IDLE and the aborted sequence is discarded.
- No combinational path from sk_ready to sk_valid or sk_data.
- Minimum time for one full sequence is 1 load cycle + 16 beats = 17 cycles.

Test Plan:
- Reverse order, key = 0x133457799BBCDFF1, decrypt = 1, sk_ready tied high:
  - sk_valid rises 1 cycle after start.
  - First beat: sk_data = 0xCB3D8B0E17F5, sk_round = 15.
  - 16th beat: sk_data = 0x1B02EFFC7072, sk_round = 0, sk_last = 1.
  - start_ready is back high 17 cycles after start.
- Forward order, same key, decrypt = 0:
  - Beat 1 = 0x1B02EFFC7072.
  - Beat 2 = 0x79AED9DBC9E5.
  - Beat 16 = 0xCB3D8B0E17F5 with sk_last = 1.
- Equivalence sweep, 1000 random keys in both modes: every beat matches the combinational 16-key schedule at the indicated sk_round. Reverse mode must be the exact mirror of forward mode.
- Back-pressure: random sk_ready (50%) → sk_data/sk_round stable while stalled; no beat lost or duplicated; exactly 16 accepted beats.
- Start while busy: pulse start with a different key at beat 5 → sequence unchanged, and start_ready stays 0.
- Reset at beat 7 → sk_valid = 0 and start_ready = 1 immediately. A following start with 0x133457799BBCDFF1 in reverse mode produces 0xCB3D8B0E17F5 first.
